// File: rtl/soc_pkg.sv
// -----------------------------------------------------------------------------
// soc_pkg: shared types and constants for the instruction fetch slice.
//   fetch_state_e : fetch FSM encoding (RUN / STOPPED)
//   NOP_INSTR     : default word substituted for a faulting fetch
//   FQ_ENTRY_W    : width of one fetch queue entry {fault, pc, instr}
//   fq_entry_t    : packed view of a fetch queue entry
// CODEMEM_SIZE gives a default code memory size when the build does not set it.
// -----------------------------------------------------------------------------
`ifndef CODEMEM_SIZE
`define CODEMEM_SIZE 32'd1024
`endif

package soc_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_STOPPED = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned FQ_ENTRY_W = 65;

  typedef struct packed {
    logic        fault;
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/soc_fetch_queue.sv
// -----------------------------------------------------------------------------
// soc_fetch_queue: generic 2-entry synchronous FIFO.
//   clk, rst_n : clock, synchronous active-low reset (entries cleared to 0)
//   flush      : empties the queue (pointers and count to 0), wins over rd/wr
//   wr_en      : enqueue wr_data; accepted when not full, or full with a read
//   wr_data    : entry to enqueue
//   rd_en      : dequeue the head; ignored when empty
//   rd_data    : current head entry (registered storage, no bypass)
//   count      : number of valid entries, 0..2
//   full/empty : count==2 / count==0
// -----------------------------------------------------------------------------
module soc_fetch_queue
  import soc_pkg::*;
#(
  parameter int unsigned W = FQ_ENTRY_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_rd, do_wr;

  assign empty   = (count_q == 2'd0);
  assign full    = (count_q == 2'd2);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A write into a full queue is legal when the head leaves the same cycle:
  // the slot being written is the one being read out.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_rd) rd_ptr_d = ~rd_ptr_q;
      if (do_wr) wr_ptr_d = ~wr_ptr_q;
      case ({do_wr, do_rd})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage is reset on purpose: with only two entries it is cheap,
  // and it makes the head read back as all-zero straight out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (do_wr && !flush) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/soc_ifetch.sv
// -----------------------------------------------------------------------------
// soc_ifetch: instruction fetch stage in front of a combinational code memory
// read port. Owns the PC, enqueues fetched words into a 2-entry queue that
// feeds decode over valid/ready, and handles redirect, halt and fetch faults.
//   clk, rst_n     : clock, synchronous active-low reset
//   imem_addr      : fetch byte address (forced to 0 while the PC is bad)
//   imem_rdata     : word returned for imem_addr in the same cycle
//   redirect_valid : execute replaces the PC and flushes the queue
//   redirect_pc    : new PC
//   halt           : level, suppresses new fetches while high
//   dec_valid/ready: handshake towards decode
//   dec_instr/pc/fault : head entry of the queue
//   fetch_cnt      : number of non-fault enqueues, wraps at 2^32
// -----------------------------------------------------------------------------
`ifndef CODEMEM_SIZE
`define CODEMEM_SIZE 32'd1024
`endif

module soc_ifetch
  import soc_pkg::fetch_state_e;
  import soc_pkg::ST_RUN;
  import soc_pkg::ST_STOPPED;
  import soc_pkg::fq_entry_t;
  import soc_pkg::FQ_ENTRY_W;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] MEM_SIZE  = `CODEMEM_SIZE,
  parameter logic [31:0] NOP_INSTR = soc_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        dec_fault,
  output logic [31:0] fetch_cnt
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fetch_cnt_q, fetch_cnt_d;

  logic         bad;
  logic         deq;
  logic         fetch_en;
  fq_entry_t    enq_entry;
  fq_entry_t    head_entry;
  logic [1:0]   q_count;
  logic         q_full;
  logic         q_empty;

  // A PC is unfetchable when misaligned or when the word would run past the
  // end of code memory; the address is then parked at 0 to keep the memory
  // index in range.
  assign bad       = (pc_q[1:0] != 2'b00) || (pc_q > (MEM_SIZE - 32'd4));
  assign imem_addr = bad ? 32'd0 : pc_q;

  // Valid comes from queue registers only; no combinational path from
  // redirect or ready.
  assign dec_valid = (q_count != 2'd0);
  assign deq       = !q_empty && dec_ready;

  assign dec_instr = head_entry.instr;
  assign dec_pc    = head_entry.pc;
  assign dec_fault = head_entry.fault;
  assign fetch_cnt = fetch_cnt_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (fetch_en && bad) state_d = ST_STOPPED;
      ST_STOPPED: state_d = ST_STOPPED;
    endcase
    // Redirect is the only way out of STOPPED and overrides everything.
    if (redirect_valid) state_d = ST_RUN;
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    fetch_en = 1'b0;
    case (state_q)
      ST_RUN:     fetch_en = !halt && !redirect_valid && (!q_full || deq);
      ST_STOPPED: fetch_en = 1'b0;
    endcase
  end

  // Entry written on a fetch: a faulting PC carries the NOP and the fault flag.
  always_comb begin
    enq_entry.fault = bad;
    enq_entry.pc    = pc_q;
    enq_entry.instr = bad ? NOP_INSTR : imem_rdata;
  end

  // ---------------- PC and fetch counter ----------------
  always_comb begin
    pc_d        = pc_q;
    fetch_cnt_d = fetch_cnt_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (fetch_en && !bad) begin
      pc_d        = pc_q + 32'd4;
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    // A faulting fetch leaves the PC where it is, pointing at the bad address.
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      fetch_cnt_q <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // ---------------- instruction queue ----------------
  // Any dequeue coinciding with a redirect is simply lost in the flush; the
  // execute stage squashes that instruction.
  soc_fetch_queue #(
    .W (FQ_ENTRY_W)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect_valid),
    .wr_en   (fetch_en),
    .wr_data (enq_entry),
    .rd_en   (dec_ready),
    .rd_data (head_entry),
    .count   (q_count),
    .full    (q_full),
    .empty   (q_empty)
  );

endmodule

// File: tb/tb_soc_ifetch.sv
// -----------------------------------------------------------------------------
// tb_soc_ifetch: self-checking bench for soc_ifetch. A table of directed
// vectors walks the reset, streaming, back-pressure, redirect, fault, end of
// memory and halt cases; a randomized phase then compares the DUT cycle by
// cycle against a queue-based reference model of the fetch rules.
// -----------------------------------------------------------------------------
module tb_soc_ifetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] MEM_SIZE = 32'd256;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_fault;
  logic [31:0] fetch_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Code memory contents: each word encodes its own byte address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  assign imem_rdata = word_at(imem_addr);

  soc_ifetch #(
    .RESET_PC  (RESET_PC),
    .MEM_SIZE  (MEM_SIZE),
    .NOP_INSTR (NOP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_fault      (dec_fault),
    .fetch_cnt      (fetch_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    bit          fault;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  bit          m_stopped;

  function automatic bit m_bad(input logic [31:0] pc);
    return (pc % 4 != 0) || (pc > MEM_SIZE - 4);
  endfunction

  task automatic model_step(input bit r, input bit rdr, input logic [31:0] rpc,
                            input bit h, input bit rdy);
    bit   can_take;
    ent_t e;
    if (!r) begin
      mq.delete();
      m_pc      = RESET_PC;
      m_cnt     = 0;
      m_stopped = 0;
    end else if (rdr) begin
      mq.delete();
      m_pc      = rpc;
      m_stopped = 0;
    end else begin
      can_take = (mq.size() < 2) || (rdy && mq.size() > 0);
      if (rdy && mq.size() > 0) void'(mq.pop_front());
      if (!m_stopped && !h && can_take) begin
        e.pc = m_pc;
        if (m_bad(m_pc)) begin
          e.instr   = NOP;
          e.fault   = 1;
          m_stopped = 1;
        end else begin
          e.instr = word_at(m_pc);
          e.fault = 0;
          m_pc    = m_pc + 4;
          m_cnt   = m_cnt + 1;
        end
        mq.push_back(e);
      end
    end
  endtask

  task automatic model_check(input int n);
    check($sformatf("rnd%0d valid", n), {31'd0, dec_valid}, {31'd0, mq.size() != 0});
    check($sformatf("rnd%0d addr", n), imem_addr, m_bad(m_pc) ? 32'd0 : m_pc);
    check($sformatf("rnd%0d fetch_cnt", n), fetch_cnt, m_cnt);
    if (mq.size() != 0) begin
      check($sformatf("rnd%0d pc", n), dec_pc, mq[0].pc);
      check($sformatf("rnd%0d instr", n), dec_instr, mq[0].instr);
      check($sformatf("rnd%0d fault", n), {31'd0, dec_fault}, {31'd0, mq[0].fault});
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rst_n;
    bit          rdr;
    logic [31:0] rpc;
    bit          halt;
    bit          rdy;
    bit          chk;      // compare outputs in this row
    bit          hd;       // also compare head fields
    bit          e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    bit          e_fault;
    logic [31:0] e_addr;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  // Reset row: outputs not compared (they reflect the state before reset).
  function automatic vec_t v_rst();
    vec_t v;
    v = '{rst_n: 0, rdr: 0, rpc: 0, halt: 0, rdy: 0, chk: 0, hd: 0, e_valid: 0,
          e_pc: 0, e_instr: 0, e_fault: 0, e_addr: 0, e_cnt: 0};
    return v;
  endfunction

  // First row after reset: everything, including the head, reads as zero.
  function automatic vec_t v_post_rst(input bit rdy);
    vec_t v;
    v = '{rst_n: 1, rdr: 0, rpc: 0, halt: 0, rdy: rdy, chk: 1, hd: 1, e_valid: 0,
          e_pc: 0, e_instr: 0, e_fault: 0, e_addr: RESET_PC, e_cnt: 0};
    return v;
  endfunction

  // Normal row; the expected instruction follows from the fault flag.
  function automatic vec_t v_row(input bit rdr, input logic [31:0] rpc, input bit h,
                                 input bit rdy, input bit ev, input logic [31:0] epc,
                                 input bit ef, input logic [31:0] eaddr,
                                 input logic [31:0] ecnt);
    vec_t v;
    v = '{rst_n: 1, rdr: rdr, rpc: rpc, halt: h, rdy: rdy, chk: 1, hd: ev, e_valid: ev,
          e_pc: epc, e_instr: ef ? NOP : word_at(epc), e_fault: ef, e_addr: eaddr,
          e_cnt: ecnt};
    return v;
  endfunction

  task automatic apply(input vec_t v, input int n, input bit use_model);
    @(negedge clk);
    rst_n          = v.rst_n;
    redirect_valid = v.rdr;
    redirect_pc    = v.rpc;
    halt           = v.halt;
    dec_ready      = v.rdy;
    #1;
    if (v.chk) begin
      check($sformatf("row%0d valid", n), {31'd0, dec_valid}, {31'd0, v.e_valid});
      check($sformatf("row%0d addr", n), imem_addr, v.e_addr);
      check($sformatf("row%0d fetch_cnt", n), fetch_cnt, v.e_cnt);
      if (v.hd) begin
        check($sformatf("row%0d pc", n), dec_pc, v.e_pc);
        check($sformatf("row%0d instr", n), dec_instr, v.e_instr);
        check($sformatf("row%0d fault", n), {31'd0, dec_fault}, {31'd0, v.e_fault});
      end
    end
    if (use_model) model_check(n);
    @(posedge clk);
    model_step(v.rst_n, v.rdr, v.rpc, v.halt, v.rdy);
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
    dec_ready      = 1'b0;

    // Streaming with ready held high: pc 0,4,8,12 back-to-back.
    vecs.push_back(v_rst());
    vecs.push_back(v_rst());
    vecs.push_back(v_post_rst(1));
    vecs.push_back(v_row(0, 0, 0, 1, 1, 32'h00, 0, 32'h04, 1));
    vecs.push_back(v_row(0, 0, 0, 1, 1, 32'h04, 0, 32'h08, 2));
    vecs.push_back(v_row(0, 0, 0, 1, 1, 32'h08, 0, 32'h0C, 3));
    vecs.push_back(v_row(0, 0, 0, 1, 1, 32'h0C, 0, 32'h10, 4));
    // Back-pressure from reset: queue fills, pc parks at 8, then drains in order.
    vecs.push_back(v_rst());
    vecs.push_back(v_post_rst(0));
    vecs.push_back(v_row(0, 0, 0, 0, 1, 32'h00, 0, 32'h04, 1));
    vecs.push_back(v_row(0, 0, 0, 0, 1, 32'h00, 0, 32'h08, 2));
    vecs.push_back(v_row(0, 0, 0, 0, 1, 32'h00, 0, 32'h08, 2));
    vecs.push_back(v_row(0, 0, 0, 0, 1, 32'h00, 0, 32'h08, 2));
    vecs.push_back(v_row(0, 0, 0, 1, 1, 32'h00, 0, 32'h08, 2));
    vecs.push_back(v_row(0, 0, 0, 1, 1, 32'h04, 0, 32'h0C, 3));
    vecs.push_back(v_row(0, 0, 0, 1, 1, 32'h08, 0, 32'h10, 4));
    vecs.push_back(v_row(0, 0, 0, 0, 1, 32'h0C, 0, 32'h14, 5));
    // Redirect into a full queue: flushed next cycle, 0x40 at the head after.
    vecs.push_back(v_row(1, 32'h40, 0, 0, 1, 32'h0C, 0, 32'h14, 5));
    vecs.push_back(v_row(0, 0, 0, 0, 0, 0, 0, 32'h40, 5));
    vecs.push_back(v_row(0, 0, 0, 0, 1, 32'h40, 0, 32'h44, 6));
    // Misaligned redirect: one fault entry, stopped, address parked at 0.
    vecs.push_back(v_row(1, 32'h42, 0, 1, 1, 32'h40, 0, 32'h48, 7));
    vecs.push_back(v_row(0, 0, 0, 0, 0, 0, 0, 32'h00, 7));
    vecs.push_back(v_row(0, 0, 0, 0, 1, 32'h42, 1, 32'h00, 7));
    vecs.push_back(v_row(0, 0, 0, 1, 1, 32'h42, 1, 32'h00, 7));
    vecs.push_back(v_row(0, 0, 0, 1, 0, 0, 0, 32'h00, 7));
    vecs.push_back(v_row(1, 32'h10, 0, 1, 0, 0, 0, 32'h00, 7));
    vecs.push_back(v_row(0, 0, 0, 1, 0, 0, 0, 32'h10, 7));
    vecs.push_back(v_row(0, 0, 0, 1, 1, 32'h10, 0, 32'h14, 8));
    // End of memory: MEM_SIZE-4 fetches normally, MEM_SIZE faults, no count.
    vecs.push_back(v_row(1, MEM_SIZE - 8, 0, 1, 1, 32'h14, 0, 32'h18, 9));
    vecs.push_back(v_row(0, 0, 0, 1, 0, 0, 0, MEM_SIZE - 8, 9));
    vecs.push_back(v_row(0, 0, 0, 1, 1, MEM_SIZE - 8, 0, MEM_SIZE - 4, 10));
    vecs.push_back(v_row(0, 0, 0, 1, 1, MEM_SIZE - 4, 0, 32'h00, 11));
    vecs.push_back(v_row(0, 0, 0, 1, 1, MEM_SIZE, 1, 32'h00, 11));
    vecs.push_back(v_row(0, 0, 0, 1, 0, 0, 0, 32'h00, 11));
    // Halt with two queued: drains, no fetch, resumes at the held pc.
    vecs.push_back(v_row(1, 32'h20, 0, 0, 0, 0, 0, 32'h00, 11));
    vecs.push_back(v_row(0, 0, 0, 0, 0, 0, 0, 32'h20, 11));
    vecs.push_back(v_row(0, 0, 0, 0, 1, 32'h20, 0, 32'h24, 12));
    vecs.push_back(v_row(0, 0, 1, 1, 1, 32'h20, 0, 32'h28, 13));
    vecs.push_back(v_row(0, 0, 1, 1, 1, 32'h24, 0, 32'h28, 13));
    vecs.push_back(v_row(0, 0, 1, 1, 0, 0, 0, 32'h28, 13));
    vecs.push_back(v_row(0, 0, 0, 1, 0, 0, 0, 32'h28, 13));
    vecs.push_back(v_row(0, 0, 0, 1, 1, 32'h28, 0, 32'h2C, 14));
    // Redirect while halted still moves the pc and flushes.
    vecs.push_back(v_row(1, 32'h80, 1, 0, 1, 32'h2C, 0, 32'h30, 15));
    vecs.push_back(v_row(0, 0, 1, 0, 0, 0, 0, 32'h80, 15));
    vecs.push_back(v_row(0, 0, 0, 0, 0, 0, 0, 32'h80, 15));
    vecs.push_back(v_row(0, 0, 0, 0, 1, 32'h80, 0, 32'h84, 16));
    vecs.push_back(v_row(0, 0, 0, 0, 1, 32'h80, 0, 32'h88, 17));
    // Reset mid-operation with a full queue leaves no residue.
    vecs.push_back(v_rst());
    vecs.push_back(v_post_rst(0));

    foreach (vecs[i]) apply(vecs[i], i, 1'b0);

    // ---------------- randomized phase against the model ----------------
    for (int n = 0; n < 600; n++) begin
      vec_t v;
      v       = v_rst();
      v.rst_n = ($urandom_range(0, 99) != 0);
      v.rdr   = ($urandom_range(0, 9) == 0);
      v.halt  = ($urandom_range(0, 4) == 0);
      v.rdy   = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 4))
        0, 1: v.rpc = 32'($urandom_range(0, 63)) * 4;
        2:    v.rpc = (32'($urandom_range(0, 63)) * 4) | 32'($urandom_range(1, 3));
        3:    v.rpc = MEM_SIZE - 32'($urandom_range(1, 4)) * 4;
        default: v.rpc = MEM_SIZE + 32'($urandom_range(0, 16)) * 4;
      endcase
      apply(v, n, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
